vga_frame_rd_sched: RTL and testbench

- Read scheduler between the DDR3 read port and the FWFT pixel FIFO that feeds the VGA timing controller.
- Each frame it sequences the burst reads needed to keep that FIFO filled.
- Selects which of two frame buffers to display and flushes the FIFO at each frame start.
- Flags underflow when the timing controller requests a pixel from an empty FIFO.

---
 rtl/vga_frame_rd_sched.sv | 137 +++++++++++++
 tb/tb_vga_frame_rd_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_rd_sched.sv
// Frame read scheduler: issues one DDR burst at a time to keep the VGA pixel FIFO filled,
// flushes the FIFO and latches the display buffer at each frame start, and flags underflow.
`timescale 1ns/1ps
module vga_frame_rd_sched #(
    parameter int unsigned       FRAME_PIXELS = 307200,
    parameter int unsigned       BURST_PIX    = 64,
    parameter int unsigned       BURST_BYTES  = 256,
    parameter int unsigned       ADDR_W       = 29,
    parameter logic [ADDR_W-1:0] BASE_ADDR0   = '0,
    parameter logic [ADDR_W-1:0] BASE_ADDR1   = ADDR_W'(32'h0200000),
    parameter int unsigned       FIFO_DEPTH   = 1024,
    parameter int unsigned       LVL_W        = 11,
    parameter int unsigned       FLUSH_CYC    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              pix_req,
    input  logic              fifo_empty,
    input  logic [LVL_W-1:0]  fifo_level,
    input  logic              wr_frame_done,
    input  logic              wr_buf,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic              rd_done,
    output logic              fifo_rst,
    output logic              rd_buf_sel,
    output logic              underflow
);
    localparam int unsigned BURSTS = FRAME_PIXELS / BURST_PIX;
    localparam int unsigned CNT_W  = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam int unsigned FL_W   = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int unsigned SUM_W  = LVL_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_SPACE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state;
    logic              vsync_d;
    logic              frame_start;
    logic              has_space;
    logic              flush_entry;
    logic              latest_buf;
    logic              latest_valid;
    logic              pending_restart;
    logic [CNT_W-1:0]  burst_cnt;
    logic [FL_W-1:0]   flush_cnt;
    logic [ADDR_W-1:0] base_addr;

    assign frame_start = vsync & ~vsync_d;
    // Level sum is one bit wider than the level so it can never wrap.
    assign has_space   = ({1'b0, fifo_level} + SUM_W'(BURST_PIX)) <= SUM_W'(FIFO_DEPTH);
    assign base_addr   = rd_buf_sel ? BASE_ADDR1 : BASE_ADDR0;

    // A burst in flight is never aborted: a restart seen in REQ/WAIT waits for rd_done.
    always_comb begin
        flush_entry = 1'b0;
        case (state)
            S_IDLE, S_SPACE, S_DONE: flush_entry = frame_start;
            S_WAIT:                  flush_entry = rd_done & (pending_restart | frame_start);
            default:                 flush_entry = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            vsync_d         <= 1'b0;
            latest_buf      <= 1'b0;
            latest_valid    <= 1'b0;
            pending_restart <= 1'b0;
            burst_cnt       <= '0;
            flush_cnt       <= '0;
            rd_req          <= 1'b0;
            rd_addr         <= '0;
            fifo_rst        <= 1'b0;
            rd_buf_sel      <= 1'b0;
            underflow       <= 1'b0;
        end else begin
            vsync_d <= vsync;

            if (wr_frame_done) begin
                latest_buf   <= wr_buf;
                latest_valid <= 1'b1;
            end

            if (flush_entry) begin
                underflow <= 1'b0;
            end else if (pix_req & fifo_empty & ~fifo_rst) begin
                underflow <= 1'b1;
            end

            if (flush_entry) begin
                state           <= S_FLUSH;
                fifo_rst        <= 1'b1;
                flush_cnt       <= '0;
                burst_cnt       <= '0;
                pending_restart <= 1'b0;
                rd_req          <= 1'b0;
                rd_buf_sel      <= latest_valid & latest_buf;
            end else begin
                case (state)
                    S_FLUSH: begin
                        if (flush_cnt == FL_W'(FLUSH_CYC - 1)) begin
                            fifo_rst <= 1'b0;
                            state    <= S_SPACE;
                        end else begin
                            flush_cnt <= flush_cnt + FL_W'(1);
                        end
                    end
                    S_SPACE: begin
                        if (has_space) begin
                            rd_addr <= base_addr + ADDR_W'(burst_cnt) * ADDR_W'(BURST_BYTES);
                            rd_req  <= 1'b1;
                            state   <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (frame_start) pending_restart <= 1'b1;
                        if (rd_ack) begin
                            rd_req <= 1'b0;
                            state  <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (frame_start) pending_restart <= 1'b1;
                        if (rd_done) begin
                            burst_cnt <= burst_cnt + CNT_W'(1);
                            state     <= (burst_cnt == CNT_W'(BURSTS - 1)) ? S_DONE : S_SPACE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vga_frame_rd_sched.sv
// Randomized bench for vga_frame_rd_sched: a bus responder plus a frame-level reference
// model (expected buffer, burst address list, flush length, sticky underflow).
`timescale 1ns/1ps
module tb_vga_frame_rd_sched;
    localparam int unsigned       FRAME_PIXELS = 256;
    localparam int unsigned       BURSTS       = 4;
    localparam int unsigned       ADDR_W       = 29;
    localparam int unsigned       LVL_W        = 11;
    localparam int unsigned       FLUSH_LEN    = 4;
    localparam logic [ADDR_W-1:0] BASE0        = 29'h0000000;
    localparam logic [ADDR_W-1:0] BASE1        = 29'h0200000;

    logic              clk = 1'b0;
    logic              rst_n, vsync, pix_req, fifo_empty, wr_frame_done, wr_buf;
    logic [LVL_W-1:0]  fifo_level;
    logic              rd_req, rd_ack, rd_done, fifo_rst, rd_buf_sel, underflow;
    logic [ADDR_W-1:0] rd_addr;

    always #5 clk = ~clk;

    vga_frame_rd_sched #(.FRAME_PIXELS(FRAME_PIXELS)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .pix_req(pix_req),
        .fifo_empty(fifo_empty), .fifo_level(fifo_level),
        .wr_frame_done(wr_frame_done), .wr_buf(wr_buf),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_done(rd_done),
        .fifo_rst(fifo_rst), .rd_buf_sel(rd_buf_sel), .underflow(underflow)
    );

    int errors = 0;
    int checks = 0;

    // Reference model and responder state
    logic              req_q = 1'b0, rst_q = 1'b0, exp_buf = 1'b0;
    logic              m_latest = 1'b0, m_valid = 1'b0, uf_m = 1'b0;
    logic [ADDR_W-1:0] addr_q = '0;
    int unsigned       exp_idx = 0;
    int                rst_run = 0, issued = 0, rs = 0, rcnt = 0;
    int                ack_fix = -1, done_fix = -1;
    logic              lvl_rnd = 1'b0, pix_rnd = 1'b0, wfd_rnd = 1'b0;
    logic [LVL_W-1:0]  lvl_fix = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: observe the edge, update the model, then drive the next cycle's inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            exp_idx = 0; exp_buf = 1'b0; m_latest = 1'b0; m_valid = 1'b0;
            uf_m = 1'b0; rst_run = 0;
        end else begin
            if (fifo_rst && !rst_q) begin
                exp_idx = 0;
                exp_buf = m_valid & m_latest;
                uf_m    = 1'b0;
            end else if (pix_req && fifo_empty && !rst_q) begin
                uf_m = 1'b1;
            end
            if (wr_frame_done) begin
                m_latest = wr_buf;
                m_valid  = 1'b1;
            end
            if (fifo_rst) begin
                rst_run++;
                check("req_in_flush", 64'(rd_req), 64'(0));
            end else if (rst_q) begin
                check("flush_len", 64'(rst_run), 64'(FLUSH_LEN));
                rst_run = 0;
            end
        end
        check("underflow", 64'(underflow), 64'(uf_m));
        check("buf_sel", 64'(rd_buf_sel), 64'(exp_buf));
        if (rd_req && !req_q) begin
            issued++;
            check("space_ok", 64'(fifo_level <= LVL_W'(960)), 64'(1));
            check("burst_idx", 64'(exp_idx < BURSTS), 64'(1));
            check("rd_addr", 64'(rd_addr), 64'((exp_buf ? BASE1 : BASE0) + ADDR_W'(exp_idx * 256)));
            exp_idx++;
        end else if (rd_req && req_q) begin
            check("addr_hold", 64'(rd_addr), 64'(addr_q));
        end
        req_q  = rd_req;
        rst_q  = fifo_rst;
        addr_q = rd_addr;

        // Read-port responder: ack after a delay, then rd_done after a further delay.
        rd_ack  = 1'b0;
        rd_done = 1'b0;
        if (rs == 0 && rd_req) begin
            rcnt = (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 3));
            rs   = 1;
        end
        if (rs == 1) begin
            if (rcnt == 0) begin
                rd_ack = 1'b1;
                rcnt   = (done_fix >= 0) ? done_fix : int'($urandom_range(1, 12));
                rs     = 2;
            end else begin
                rcnt--;
            end
        end else if (rs == 2) begin
            rcnt--;
            if (rcnt <= 0) begin
                rd_done = 1'b1;
                rs      = 0;
            end
        end

        if (lvl_rnd)
            fifo_level = ($urandom_range(0, 3) == 0) ? LVL_W'($urandom_range(961, 1023))
                                                     : LVL_W'($urandom_range(0, 960));
        else
            fifo_level = lvl_fix;
        if (pix_rnd) begin
            pix_req    = ($urandom_range(0, 15) == 0);
            fifo_empty = 1'($urandom_range(0, 1));
        end
        wr_frame_done = 1'b0;
        if (wfd_rnd && $urandom_range(0, 150) == 0) begin
            wr_frame_done = 1'b1;
            wr_buf        = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic start_frame();
        vsync = 1'b1;
        tick();
        tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic wait_frame(input string tag, input int budget);
        int n = 0;
        while (!(exp_idx == BURSTS && rs == 0 && !rd_req) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(exp_idx), 64'(BURSTS));
    endtask

    task automatic wait_issue(input string tag, input int target, input int budget);
        int n = 0;
        while (issued < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(issued >= target), 64'(1));
    endtask

    task automatic wait_ack(input string tag, input int budget);
        int n = 0;
        while (rs != 2 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(rs), 64'(2));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0; vsync = 1'b0; pix_req = 1'b0; fifo_empty = 1'b0;
        fifo_level = '0; wr_frame_done = 1'b0; wr_buf = 1'b0;
        rd_ack = 1'b0; rd_done = 1'b0;

        repeat (3) tick();
        check("rst_rd_req", 64'(rd_req), 64'(0));
        check("rst_rd_addr", 64'(rd_addr), 64'(0));
        check("rst_fifo_rst", 64'(fifo_rst), 64'(0));
        check("rst_buf_sel", 64'(rd_buf_sel), 64'(0));
        check("rst_underflow", 64'(underflow), 64'(0));
        rst_n = 1'b1;
        tick();

        // First frame: latency from vsync edge to first request, then 4 bursts and idle
        ack_fix = 2; done_fix = 10; issued = 0; lat = 0;
        vsync = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 2) vsync = 1'b0;
            if (rd_req && lat == 0) lat = n;
        end
        check("first_req_latency", 64'(lat), 64'(6));
        check("first_req_addr_base0", 64'(issued >= 1), 64'(1));
        wait_frame("frame1_done", 400);
        repeat (40) tick();
        check("frame1_bursts", 64'(issued), 64'(BURSTS));

        // Backpressure at the exact space boundary
        lvl_fix = 11'd961; fifo_level = 11'd961; issued = 0;
        start_frame();
        repeat (30) tick();
        check("bp_hold_req", 64'(rd_req), 64'(0));
        check("bp_hold_cnt", 64'(issued), 64'(0));
        lvl_fix = 11'd960; fifo_level = 11'd960;
        tick();
        check("bp_release", 64'(rd_req), 64'(1));
        wait_frame("bp_frame_done", 400);
        lvl_fix = '0; fifo_level = '0;

        // Buffer switch requested mid-frame takes effect only at the next frame
        ack_fix = -1; done_fix = -1; issued = 0;
        start_frame();
        wait_issue("sw_mid_frame", 2, 200);
        wr_buf = 1'b1; wr_frame_done = 1'b1;
        tick();
        wait_frame("sw_frame_done", 400);
        check("sw_hold_buf0", 64'(rd_buf_sel), 64'(0));
        vsync = 1'b1;
        tick();
        check("sw_buf1", 64'(rd_buf_sel), 64'(1));
        tick();
        vsync = 1'b0;
        issued = 0;
        wait_issue("sw_first_req", 1, 40);
        check("sw_addr_base1", 64'(rd_addr), 64'(BASE1));
        wait_frame("sw_buf1_done", 400);

        // Restart while a burst is outstanding
        done_fix = 10; issued = 0;
        start_frame();
        wait_ack("rs_ack_seen", 200);
        tick();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (rd_done) break;
            tick();
            check("rs_no_early_flush", 64'(fifo_rst), 64'(0));
        end
        check("rs_done_seen", 64'(rd_done), 64'(1));
        tick();
        check("rs_flush", 64'(fifo_rst), 64'(1));
        issued = 0;
        wait_issue("rs_first_req", 1, 40);
        check("rs_addr_base", 64'(rd_addr), 64'(BASE1));
        wait_frame("rs_frame_done", 400);
        done_fix = -1;

        // Underflow: sticky, cleared at frame start, masked during flush
        pix_req = 1'b1; fifo_empty = 1'b1;
        tick();
        tick();
        check("uf_set", 64'(underflow), 64'(1));
        pix_req = 1'b0;
        repeat (5) tick();
        check("uf_sticky", 64'(underflow), 64'(1));
        pix_req = 1'b1;
        vsync = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 2) vsync = 1'b0;
            if (fifo_rst) check("uf_in_flush", 64'(underflow), 64'(0));
        end
        check("uf_after_flush", 64'(underflow), 64'(1));
        pix_req = 1'b0; fifo_empty = 1'b0;
        wait_frame("uf_frame_done", 400);

        // Reset in the middle of a burst; the late rd_done must be ignored
        done_fix = 12;
        start_frame();
        wait_ack("rb_ack_seen", 200);
        rst_n = 1'b0;
        tick();
        check("rb_rd_req", 64'(rd_req), 64'(0));
        check("rb_fifo_rst", 64'(fifo_rst), 64'(0));
        check("rb_buf_sel", 64'(rd_buf_sel), 64'(0));
        check("rb_rd_addr", 64'(rd_addr), 64'(0));
        tick();
        rst_n = 1'b1;
        issued = 0;
        repeat (30) tick();
        check("rb_no_req", 64'(issued), 64'(0));
        done_fix = -1;
        start_frame();
        wait_issue("rb_first_req", 1, 40);
        check("rb_addr_base0", 64'(rd_addr), 64'(BASE0));
        wait_frame("rb_frame_done", 400);

        // Randomized traffic: random levels, pixel requests, buffer writes and restarts
        lvl_rnd = 1'b1; pix_rnd = 1'b1; wfd_rnd = 1'b1;
        for (int f = 0; f < 12; f++) begin
            vsync = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            vsync = 1'b0;
            repeat ($urandom_range(40, 500)) tick();
        end
        wait_frame("rand_final_done", 3000);
        lvl_rnd = 1'b0; pix_rnd = 1'b0; wfd_rnd = 1'b0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
